// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: operation codes, error cause
// codes and the legality/cause rules that decide whether an operation may
// execute against the current occupancy.
package stack_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_REPL1 = 3'd5;
  localparam logic [2:0] OP_REPL2 = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;

  // True when op can execute with cnt entries on a stack of the given depth.
  function automatic logic op_legal(input logic [2:0] op,
                                    input int unsigned cnt,
                                    input int unsigned depth);
    case (op)
      OP_PUSH:            return cnt < depth;
      OP_POP, OP_REPL1:   return cnt >= 1;
      OP_DUP:             return (cnt >= 1) && (cnt < depth);
      OP_SWAP, OP_REPL2:  return cnt >= 2;
      default:            return 1'b1;  // NOP and CLEAR
    endcase
  endfunction

  // Cause for an illegal op. DUP on an empty stack is an underflow even
  // though it would also grow the stack, so the empty test comes first.
  function automatic logic [1:0] op_cause(input logic [2:0] op,
                                          input int unsigned cnt);
    if (op == OP_PUSH) return ERR_OVF;
    if (op == OP_DUP && cnt != 0) return ERR_OVF;
    return ERR_UNF;
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Combinational decode of one stack operation.
// Inputs : op_valid, op_code, count (current occupancy).
// Outputs: accept/reject strobes, error cause, clear, write enables for the
//          slot above TOS (new), the TOS slot and the NOS slot with their
//          data source selects, and the next occupancy count.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 op_valid,
  input  logic [2:0]           op_code,
  input  logic [CNT_WIDTH-1:0] count,
  output logic                 accept,
  output logic                 reject,
  output logic [1:0]           cause,
  output logic                 clear,
  output logic                 new_en,        // write slot at index count
  output logic                 new_from_tos,  // else data_in
  output logic                 top_en,        // write slot at count-1
  output logic                 top_from_nos,  // else data_in
  output logic                 nos_en,        // write slot at count-2
  output logic                 nos_from_tos,  // else data_in
  output logic [CNT_WIDTH-1:0] count_nxt
);

  logic legal;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    legal        = op_legal(op_code, 32'(count), DEPTH);
    accept       = op_valid && legal;
    reject       = op_valid && !legal;
    cause        = op_cause(op_code, 32'(count));
    clear        = 1'b0;
    new_en       = 1'b0;
    new_from_tos = 1'b0;
    top_en       = 1'b0;
    top_from_nos = 1'b0;
    nos_en       = 1'b0;
    nos_from_tos = 1'b0;
    count_nxt    = count;
    if (accept) begin
      case (op_code)
        OP_PUSH: begin
          new_en    = 1'b1;
          count_nxt = count + CNT_WIDTH'(1);
        end
        OP_POP: count_nxt = count - CNT_WIDTH'(1);
        OP_DUP: begin
          new_en       = 1'b1;
          new_from_tos = 1'b1;
          count_nxt    = count + CNT_WIDTH'(1);
        end
        OP_SWAP: begin
          top_en       = 1'b1;
          top_from_nos = 1'b1;
          nos_en       = 1'b1;
          nos_from_tos = 1'b1;
        end
        OP_REPL1: top_en = 1'b1;
        // Binary result lands in the NOS slot, which becomes the new TOS.
        OP_REPL2: begin
          nos_en    = 1'b1;
          count_nxt = count - CNT_WIDTH'(1);
        end
        OP_CLEAR: begin
          clear     = 1'b1;
          count_nxt = '0;
        end
        default: ;  // NOP
      endcase
    end
  end

endmodule

// File: rtl/stack_unit.sv
// Operand stack with TOS/NOS taps for the ULA operand path.
// Inputs : clk, reset (async, active low), op_valid, op_code, data_in.
// Outputs: tos_out, nos_out (0 when out of range), count, empty, full,
//          err (sticky), err_code (first cause), op_done (pulse per legal op).
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [2:0]            op_code,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] tos_out,
  output logic [DATA_WIDTH-1:0] nos_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  op_done
);

  localparam int IDX_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  op_done_q, op_done_d;

  logic                  accept, reject, clear;
  logic [1:0]            cause;
  logic                  new_en, new_from_tos, top_en, top_from_nos;
  logic                  nos_en, nos_from_tos;
  logic [IDX_WIDTH-1:0]  new_idx, tos_idx, nos_idx;

  stack_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .op_valid     (op_valid),
    .op_code      (op_code),
    .count        (count_q),
    .accept       (accept),
    .reject       (reject),
    .cause        (cause),
    .clear        (clear),
    .new_en       (new_en),
    .new_from_tos (new_from_tos),
    .top_en       (top_en),
    .top_from_nos (top_from_nos),
    .nos_en       (nos_en),
    .nos_from_tos (nos_from_tos),
    .count_nxt    (count_d)
  );

  // Indices may wrap when out of range; the range guards below and the
  // legality gating on the enables make the wrapped values harmless.
  assign new_idx = IDX_WIDTH'(count_q);
  assign tos_idx = IDX_WIDTH'(count_q - CNT_WIDTH'(1));
  assign nos_idx = IDX_WIDTH'(count_q - CNT_WIDTH'(2));

  assign tos_out  = (count_q >= CNT_WIDTH'(1)) ? mem_q[tos_idx] : '0;
  assign nos_out  = (count_q >= CNT_WIDTH'(2)) ? mem_q[nos_idx] : '0;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_WIDTH'(DEPTH));
  assign err      = err_q;
  assign err_code = err_code_q;
  assign op_done  = op_done_q;

  always_comb begin
    mem_d = mem_q;
    if (new_en) mem_d[new_idx] = new_from_tos ? tos_out : data_in;
    if (top_en) mem_d[tos_idx] = top_from_nos ? nos_out : data_in;
    if (nos_en) mem_d[nos_idx] = nos_from_tos ? tos_out : data_in;
  end

  // The first cause is kept until CLEAR; later errors only hold err high.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    op_done_d  = accept;
    if (clear) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end else if (reject) begin
      err_d = 1'b1;
      if (!err_q) err_code_d = cause;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the entry array is reset too, since entries must read as zero
      // after reset; this is a flop array, not a RAM macro.
      mem_q      <= '{default: '0};
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      op_done_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      op_done_q  <= op_done_d;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench: two stacks (DEPTH=4 and DEPTH=2) driven by the same
// stimulus and compared each cycle against a plain array/count model.
module tb_stack_unit;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                         SWAP = 3'd4, REPL1 = 3'd5, REPL2 = 3'd6, CLEAR = 3'd7;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic [2:0] op_code;
  logic [7:0] data_in;

  logic [7:0] tos_o   [2];
  logic [7:0] nos_o   [2];
  logic       empty_o [2];
  logic       full_o  [2];
  logic       err_o   [2];
  logic [1:0] code_o  [2];
  logic       done_o  [2];
  logic [2:0] cnt0;
  logic [1:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: visible entries m_mem[i][0..m_cnt-1], bottom at index 0.
  logic [7:0] m_mem  [2][4];
  int         m_cnt  [2];
  logic       m_err  [2];
  logic [1:0] m_code [2];
  logic       m_done [2];

  stack_unit #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .data_in(data_in), .tos_out(tos_o[0]), .nos_out(nos_o[0]), .count(cnt0),
    .empty(empty_o[0]), .full(full_o[0]), .err(err_o[0]),
    .err_code(code_o[0]), .op_done(done_o[0])
  );

  stack_unit #(.DATA_WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .data_in(data_in), .tos_out(tos_o[1]), .nos_out(nos_o[1]), .count(cnt1),
    .empty(empty_o[1]), .full(full_o[1]), .err(err_o[1]),
    .err_code(code_o[1]), .op_done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_err[i] = 1'b0; m_code[i] = 2'd0; m_done[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_mem[i][k] = 8'h00;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic [2:0] op,
                            input logic [7:0] d);
    int n;
    int dp;
    bit ok;
    logic [1:0] why;
    logic [7:0] t;
    n = m_cnt[i];
    dp = depth_of(i);
    m_done[i] = 1'b0;
    if (!v) return;
    ok = 1'b1;
    why = 2'd2;
    case (op)
      PUSH:        begin ok = n < dp; why = 2'd1; end
      POP, REPL1:  ok = n >= 1;
      DUP:         begin ok = (n >= 1) && (n < dp); why = (n == 0) ? 2'd2 : 2'd1; end
      SWAP, REPL2: ok = n >= 2;
      default:     ok = 1'b1;
    endcase
    if (!ok) begin
      if (!m_err[i]) m_code[i] = why;
      m_err[i] = 1'b1;
      return;
    end
    m_done[i] = 1'b1;
    case (op)
      PUSH:  begin m_mem[i][n] = d; m_cnt[i] = n + 1; end
      POP:   m_cnt[i] = n - 1;
      DUP:   begin m_mem[i][n] = m_mem[i][n-1]; m_cnt[i] = n + 1; end
      SWAP:  begin t = m_mem[i][n-1]; m_mem[i][n-1] = m_mem[i][n-2]; m_mem[i][n-2] = t; end
      REPL1: m_mem[i][n-1] = d;
      REPL2: begin m_mem[i][n-2] = d; m_cnt[i] = n - 1; end
      CLEAR: begin m_cnt[i] = 0; m_err[i] = 1'b0; m_code[i] = 2'd0; end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string ctx);
    for (int i = 0; i < 2; i++) begin
      int n;
      int dp;
      logic [31:0] cnt_act;
      n = m_cnt[i];
      dp = depth_of(i);
      cnt_act = (i == 0) ? 32'(cnt0) : 32'(cnt1);
      check($sformatf("%s d%0d count", ctx, dp), cnt_act, 32'(n));
      check($sformatf("%s d%0d tos", ctx, dp), 32'(tos_o[i]),
            (n >= 1) ? 32'(m_mem[i][n-1]) : 32'd0);
      check($sformatf("%s d%0d nos", ctx, dp), 32'(nos_o[i]),
            (n >= 2) ? 32'(m_mem[i][n-2]) : 32'd0);
      check($sformatf("%s d%0d empty", ctx, dp), 32'(empty_o[i]), 32'(n == 0));
      check($sformatf("%s d%0d full", ctx, dp), 32'(full_o[i]), 32'(n == dp));
      check($sformatf("%s d%0d err", ctx, dp), 32'(err_o[i]), 32'(m_err[i]));
      check($sformatf("%s d%0d err_code", ctx, dp), 32'(code_o[i]), 32'(m_code[i]));
      check($sformatf("%s d%0d op_done", ctx, dp), 32'(done_o[i]), 32'(m_done[i]));
    end
  endtask

  task automatic do_op(input logic v, input logic [2:0] op, input logic [7:0] d,
                       input string ctx);
    op_valid = v;
    op_code  = op;
    data_in  = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, v, op, d);
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    op_valid = 1'b0;
    op_code  = NOP;
    data_in  = 8'h00;
    reset    = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    #2 check_outputs("reset");
    @(negedge clk) reset = 1'b1;

    // Basic push / swap / binary replace
    do_op(1, PUSH, 8'h11, "push1");
    do_op(1, PUSH, 8'h22, "push2");
    check("plan tos 22", 32'(tos_o[0]), 32'h22);
    check("plan nos 11", 32'(nos_o[0]), 32'h11);
    do_op(1, SWAP, 8'h00, "swap");
    check("plan swap tos", 32'(tos_o[0]), 32'h11);
    do_op(1, REPL2, 8'h33, "repl2");
    check("plan repl2 tos", 32'(tos_o[0]), 32'h33);
    check("plan repl2 count", 32'(cnt0), 32'd1);

    // Fill to overflow
    do_op(1, CLEAR, 8'h00, "clear1");
    for (int k = 1; k <= 5; k++) do_op(1, PUSH, 8'(k), $sformatf("fill%0d", k));
    check("plan ovf code", 32'(code_o[0]), 32'd1);
    check("plan ovf tos", 32'(tos_o[0]), 32'd4);
    check("plan ovf done", 32'(done_o[0]), 32'd0);

    // Underflow from empty, then legal ops while err is set
    do_op(1, CLEAR, 8'h00, "clear2");
    do_op(1, POP, 8'h00, "unf_pop");
    check("plan unf code", 32'(code_o[0]), 32'd2);
    do_op(1, PUSH, 8'h07, "push_after_err");
    do_op(1, PUSH, 8'h08, "push_after_err2");
    do_op(1, PUSH, 8'h09, "ovf_after_unf");
    do_op(1, CLEAR, 8'h00, "clear3");
    do_op(1, DUP, 8'h00, "dup_empty");
    check("plan dup empty code", 32'(code_o[0]), 32'd2);
    do_op(1, CLEAR, 8'h00, "clear4");

    // DUP and REPL1
    do_op(1, PUSH, 8'h05, "push5");
    do_op(1, DUP, 8'h00, "dup");
    check("plan dup nos", 32'(nos_o[0]), 32'h05);
    do_op(1, REPL1, 8'h09, "repl1");
    do_op(1, NOP, 8'h00, "nop");
    do_op(0, PUSH, 8'hAA, "idle");

    // Asynchronous reset mid-cycle with an op held valid
    do_op(1, CLEAR, 8'h00, "clear5");
    for (int k = 0; k < 3; k++) do_op(1, PUSH, 8'(8'h40 + k), "pre_rst");
    op_valid = 1'b1;
    op_code  = PUSH;
    data_in  = 8'h5A;
    #1 reset = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    @(posedge clk);
    #1 check_outputs("rst_hold");
    @(negedge clk) reset = 1'b1;

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      int r;
      logic [2:0] op;
      r  = $urandom_range(0, 15);
      op = (r == 15) ? CLEAR : 3'(r % 7);
      do_op($urandom_range(0, 9) != 0, op, 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
